// File: rtl/br_ckpt_pkg.sv
// Shared types and default geometry for the branch checkpoint stack.
// Each map-table entry is {rdy, tag}, so rdy is the MSB of every packed entry.
package br_ckpt_pkg;

  localparam int DEF_DEPTH     = 4;
  localparam int DEF_MT_NUM    = 32;
  localparam int DEF_PRF_IDX_W = 6;
  localparam int DEF_FL_PTR_W  = 5;
  localparam int DEF_CNT_W     = $clog2(DEF_DEPTH + 1);

  typedef struct packed {
    logic                     rdy;
    logic [DEF_PRF_IDX_W-1:0] tag;
  } mt_ent_t;

  typedef mt_ent_t [DEF_MT_NUM-1:0] mt_snap_t;
  typedef logic [DEF_FL_PTR_W:0]    fl_ptr_t;
  typedef logic [DEF_DEPTH-1:0]     br_mask_t;

  // Classification of the resolve port for the current cycle.
  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_CORRECT = 2'd1,
    RES_WRONG   = 2'd2
  } res_kind_e;

endpackage

// File: rtl/br_ckpt_ent.sv
// One checkpoint slot: map-table image, free-list head and dependency mask.
// Snoops the CDB continuously and drops dependency bits of correctly resolved branches.
module br_ckpt_ent
  import br_ckpt_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MT_NUM    = DEF_MT_NUM,
  parameter int PRF_IDX_W = DEF_PRF_IDX_W,
  parameter int FL_PTR_W  = DEF_FL_PTR_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_wr,
  input  logic [MT_NUM*(PRF_IDX_W+1)-1:0] i_snap,
  input  logic [FL_PTR_W:0]               i_fl_head,
  input  logic [DEPTH-1:0]                i_dep,
  input  logic [DEPTH-1:0]                i_clr,
  input  logic                            i_cdb_vld,
  input  logic [PRF_IDX_W-1:0]            i_cdb_tag,
  output logic [MT_NUM*(PRF_IDX_W+1)-1:0] o_mt,
  output logic [FL_PTR_W:0]               o_fl_head,
  output logic [DEPTH-1:0]                o_dep
);

  localparam int EW  = PRF_IDX_W + 1;
  localparam int MTW = MT_NUM * EW;

  logic [MTW-1:0]       r_mt;
  logic [FL_PTR_W:0]    r_fl_head;
  logic [DEPTH-1:0]     r_dep;
  logic [MTW-1:0]       w_mt_upd;

  // Stored image with this cycle's CDB broadcast already applied; also the recovery view.
  always_comb begin
    w_mt_upd = r_mt;
    for (int j = 0; j < MT_NUM; j++) begin
      if (i_cdb_vld && (r_mt[j*EW +: PRF_IDX_W] == i_cdb_tag)) begin
        w_mt_upd[j*EW + PRF_IDX_W] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mt      <= '0;
      r_fl_head <= '0;
      r_dep     <= '0;
    end else if (i_wr) begin
      r_mt      <= i_snap;
      r_fl_head <= i_fl_head;
      r_dep     <= i_dep;
    end else begin
      r_mt      <= w_mt_upd;
      r_dep     <= r_dep & ~i_clr;
    end
  end

  assign o_mt      = w_mt_upd;
  assign o_fl_head = r_fl_head;
  assign o_dep     = r_dep;

endmodule

// File: rtl/br_ckpt_stack.sv
// Branch checkpoint stack: one-hot allocation, nested squash through dependency masks,
// registered recovery outputs and CDB ready-bit snooping with same-cycle bypass.
module br_ckpt_stack
  import br_ckpt_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MT_NUM    = DEF_MT_NUM,
  parameter int PRF_IDX_W = DEF_PRF_IDX_W,
  parameter int FL_PTR_W  = DEF_FL_PTR_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alloc_i,
  input  logic [MT_NUM*(PRF_IDX_W+1)-1:0]   mt_snap_i,
  input  logic [FL_PTR_W:0]                 fl_head_i,
  output logic                              alloc_rdy_o,
  output logic [DEPTH-1:0]                  alloc_bit_o,
  output logic [DEPTH-1:0]                  br_mask_o,
  output logic                              full_o,
  output logic [$clog2(DEPTH+1)-1:0]        free_cnt_o,
  input  logic                              res_vld_i,
  input  logic                              res_wrong_i,
  input  logic [DEPTH-1:0]                  res_bit_i,
  output logic [DEPTH-1:0]                  br_bit_o,
  input  logic                              cdb_vld_i,
  input  logic [PRF_IDX_W-1:0]              cdb_tag_i,
  output logic                              rc_vld_o,
  output logic [MT_NUM*(PRF_IDX_W+1)-1:0]   rc_mt_o,
  output logic [FL_PTR_W:0]                 rc_fl_head_o,
  output logic [DEPTH-1:0]                  sq_mask_o
);

  localparam int EW  = PRF_IDX_W + 1;
  localparam int MTW = MT_NUM * EW;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  r_br_mask;
  logic              r_rc_vld;
  logic [MTW-1:0]    r_rc_mt;
  logic [FL_PTR_W:0] r_rc_fl_head;
  logic [DEPTH-1:0]  r_sq_mask;

  logic              w_full;
  logic              w_res_hit;
  res_kind_e         w_res_kind;
  logic              w_alloc;
  logic [DEPTH-1:0]  w_alloc_bit;
  logic [DEPTH-1:0]  w_clr;
  logic [DEPTH-1:0]  w_alloc_dep;
  logic [MTW-1:0]    w_snap_byp;
  logic [CW-1:0]     w_busy_cnt;
  logic [MTW-1:0]    w_rc_mt;
  logic [FL_PTR_W:0] w_rc_fl_head;
  logic [DEPTH-1:0]  w_rc_dep;

  logic [MTW-1:0]    w_ent_mt      [DEPTH];
  logic [FL_PTR_W:0] w_ent_fl_head [DEPTH];
  logic [DEPTH-1:0]  w_ent_dep     [DEPTH];

  assign w_full = &r_br_mask;

  // Resolves naming a branch that is not in flight are ignored entirely.
  assign w_res_hit = res_vld_i && ((res_bit_i & r_br_mask) != '0);

  always_comb begin
    w_res_kind = RES_NONE;
    if (w_res_hit) begin
      w_res_kind = res_wrong_i ? RES_WRONG : RES_CORRECT;
    end
  end

  // Lowest free index, chosen from the registered mask only.
  always_comb begin
    w_alloc_bit = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!r_br_mask[k]) begin
        w_alloc_bit    = '0;
        w_alloc_bit[k] = 1'b1;
      end
    end
  end

  assign alloc_rdy_o = !w_full && !(res_vld_i && res_wrong_i);
  assign w_alloc     = alloc_i && alloc_rdy_o;
  assign w_clr       = (w_res_kind == RES_CORRECT) ? res_bit_i : '0;
  assign w_alloc_dep = r_br_mask & ~w_clr;

  // CDB bypass into the incoming snapshot, shared by all slots.
  always_comb begin
    w_snap_byp = mt_snap_i;
    for (int j = 0; j < MT_NUM; j++) begin
      if (cdb_vld_i && (mt_snap_i[j*EW +: PRF_IDX_W] == cdb_tag_i)) begin
        w_snap_byp[j*EW + PRF_IDX_W] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    br_ckpt_ent #(
      .DEPTH     (DEPTH),
      .MT_NUM    (MT_NUM),
      .PRF_IDX_W (PRF_IDX_W),
      .FL_PTR_W  (FL_PTR_W)
    ) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr      (w_alloc && w_alloc_bit[g]),
      .i_snap    (w_snap_byp),
      .i_fl_head (fl_head_i),
      .i_dep     (w_alloc_dep),
      .i_clr     (w_clr),
      .i_cdb_vld (cdb_vld_i),
      .i_cdb_tag (cdb_tag_i),
      .o_mt      (w_ent_mt[g]),
      .o_fl_head (w_ent_fl_head[g]),
      .o_dep     (w_ent_dep[g])
    );
  end

  // One-hot recovery mux over the resolved slot.
  always_comb begin
    w_rc_mt      = '0;
    w_rc_fl_head = '0;
    w_rc_dep     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (res_bit_i[k]) begin
        w_rc_mt      = w_rc_mt | w_ent_mt[k];
        w_rc_fl_head = w_rc_fl_head | w_ent_fl_head[k];
        w_rc_dep     = w_rc_dep | w_ent_dep[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_mask    <= '0;
      r_rc_vld     <= 1'b0;
      r_rc_mt      <= '0;
      r_rc_fl_head <= '0;
      r_sq_mask    <= '0;
    end else begin
      r_rc_vld  <= (w_res_kind == RES_WRONG);
      r_sq_mask <= '0;
      if (w_res_kind == RES_WRONG) begin
        r_br_mask    <= w_rc_dep;
        r_rc_mt      <= w_rc_mt;
        r_rc_fl_head <= w_rc_fl_head;
        r_sq_mask    <= r_br_mask & ~w_rc_dep;
      end else begin
        r_br_mask <= (r_br_mask & ~w_clr) | (w_alloc ? w_alloc_bit : '0);
      end
    end
  end

  always_comb begin
    w_busy_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_busy_cnt = w_busy_cnt + CW'(r_br_mask[k]);
    end
  end

  assign free_cnt_o   = CW'(DEPTH) - w_busy_cnt;
  assign full_o       = w_full;
  assign alloc_bit_o  = w_alloc_bit;
  assign br_mask_o    = r_br_mask;
  assign br_bit_o     = res_vld_i ? res_bit_i : '0;
  assign rc_vld_o     = r_rc_vld;
  assign rc_mt_o      = r_rc_mt;
  assign rc_fl_head_o = r_rc_fl_head;
  assign sq_mask_o    = r_sq_mask;

endmodule

// File: tb/tb_br_ckpt_stack.sv
// Directed bench for br_ckpt_stack: allocation order, full blocking, nested squash,
// CDB snoop/bypass into recovery data, and asynchronous reset during recovery.
module tb_br_ckpt_stack;
  import br_ckpt_pkg::*;

  localparam int DEPTH = 4;
  localparam int MTW   = DEF_MT_NUM * (DEF_PRF_IDX_W + 1);

  logic             clk;
  logic             rst_n;
  logic             alloc_i;
  logic [MTW-1:0]   mt_snap_i;
  logic [5:0]       fl_head_i;
  logic             alloc_rdy_o;
  logic [3:0]       alloc_bit_o;
  logic [3:0]       br_mask_o;
  logic             full_o;
  logic [2:0]       free_cnt_o;
  logic             res_vld_i;
  logic             res_wrong_i;
  logic [3:0]       res_bit_i;
  logic [3:0]       br_bit_o;
  logic             cdb_vld_i;
  logic [5:0]       cdb_tag_i;
  logic             rc_vld_o;
  logic [MTW-1:0]   rc_mt_o;
  logic [5:0]       rc_fl_head_o;
  logic [3:0]       sq_mask_o;

  int checks = 0;
  int errors = 0;

  br_ckpt_stack u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_i      (alloc_i),
    .mt_snap_i    (mt_snap_i),
    .fl_head_i    (fl_head_i),
    .alloc_rdy_o  (alloc_rdy_o),
    .alloc_bit_o  (alloc_bit_o),
    .br_mask_o    (br_mask_o),
    .full_o       (full_o),
    .free_cnt_o   (free_cnt_o),
    .res_vld_i    (res_vld_i),
    .res_wrong_i  (res_wrong_i),
    .res_bit_i    (res_bit_i),
    .br_bit_o     (br_bit_o),
    .cdb_vld_i    (cdb_vld_i),
    .cdb_tag_i    (cdb_tag_i),
    .rc_vld_o     (rc_vld_o),
    .rc_mt_o      (rc_mt_o),
    .rc_fl_head_o (rc_fl_head_o),
    .sq_mask_o    (sq_mask_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot k: entry j holds tag (j + 8k) mod 64, rdy = 0.
  function automatic mt_snap_t make_snap(input int k);
    mt_snap_t s;
    for (int j = 0; j < DEF_MT_NUM; j++) begin
      s[j].rdy = 1'b0;
      s[j].tag = 6'((j + 8 * k) % 64);
    end
    return s;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alloc_i     = 1'b0;
    mt_snap_i   = '0;
    fl_head_i   = '0;
    res_vld_i   = 1'b0;
    res_wrong_i = 1'b0;
    res_bit_i   = '0;
    cdb_vld_i   = 1'b0;
    cdb_tag_i   = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_alloc(input int k, input logic [5:0] fl);
    alloc_i   = 1'b1;
    mt_snap_i = make_snap(k);
    fl_head_i = fl;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (br_mask_o !== 4'b0000) begin errors++; $display("FAIL reset_mask got %b exp 0000", br_mask_o); end
    checks++; if (free_cnt_o !== 3'd4) begin errors++; $display("FAIL reset_free_cnt got %0d exp 4", free_cnt_o); end
    checks++; if (full_o !== 1'b0 || alloc_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_full_rdy got %b%b exp 01", full_o, alloc_rdy_o); end
    checks++; if (rc_vld_o !== 1'b0 || sq_mask_o !== 4'b0000) begin errors++; $display("FAIL reset_rc got %b/%b exp 0/0000", rc_vld_o, sq_mask_o); end
    checks++; if (alloc_bit_o !== 4'b0001) begin errors++; $display("FAIL reset_alloc_bit got %b exp 0001", alloc_bit_o); end
  endtask

  task automatic test_alloc_fill();
    logic [3:0] exp_bit;
    for (int k = 0; k < 4; k++) begin
      exp_bit = 4'b0001 << k;
      checks++; if (alloc_bit_o !== exp_bit) begin errors++; $display("FAIL fill_alloc_bit%0d got %b exp %b", k, alloc_bit_o, exp_bit); end
      do_alloc(k, 6'(10 + k));
    end
    checks++; if (br_mask_o !== 4'b1111) begin errors++; $display("FAIL fill_mask got %b exp 1111", br_mask_o); end
    checks++; if (full_o !== 1'b1 || free_cnt_o !== 3'd0) begin errors++; $display("FAIL fill_full got %b/%0d exp 1/0", full_o, free_cnt_o); end
    checks++; if (alloc_rdy_o !== 1'b0 || alloc_bit_o !== 4'b0000) begin errors++; $display("FAIL fill_rdy got %b/%b exp 0/0000", alloc_rdy_o, alloc_bit_o); end
  endtask

  task automatic test_full_correct();
    alloc_i   = 1'b1;
    mt_snap_i = make_snap(5);
    fl_head_i = 6'd15;
    res_vld_i = 1'b1;
    res_bit_i = 4'b0010;
    #1;
    checks++; if (br_bit_o !== 4'b0010) begin errors++; $display("FAIL fc_br_bit got %b exp 0010", br_bit_o); end
    checks++; if (alloc_rdy_o !== 1'b0) begin errors++; $display("FAIL fc_rdy_full got %b exp 0", alloc_rdy_o); end
    tick();
    idle_inputs();
    checks++; if (br_mask_o !== 4'b1101) begin errors++; $display("FAIL fc_mask got %b exp 1101", br_mask_o); end
    checks++; if (alloc_bit_o !== 4'b0010 || free_cnt_o !== 3'd1) begin errors++; $display("FAIL fc_next_alloc got %b/%0d exp 0010/1", alloc_bit_o, free_cnt_o); end
    do_alloc(5, 6'd15);
    checks++; if (br_mask_o !== 4'b1111) begin errors++; $display("FAIL fc_realloc got %b exp 1111", br_mask_o); end
    // Slot 2 dep was 0011; the correct resolve of bit 1 leaves 0001.
    res_vld_i = 1'b1; res_wrong_i = 1'b1; res_bit_i = 4'b0100;
    tick();
    res_bit_i = 4'b0001;
    checks++; if (rc_vld_o !== 1'b1 || br_mask_o !== 4'b0001 || sq_mask_o !== 4'b1110) begin
      errors++; $display("FAIL nest_sq got %b/%b/%b exp 1/0001/1110", rc_vld_o, br_mask_o, sq_mask_o); end
    checks++; if (rc_mt_o !== make_snap(2) || rc_fl_head_o !== 6'd12) begin errors++; $display("FAIL nest_rc got fl %0d exp 12 (mt %h)", rc_fl_head_o, rc_mt_o); end
    tick();
    idle_inputs();
    checks++; if (rc_vld_o !== 1'b1 || br_mask_o !== 4'b0000 || sq_mask_o !== 4'b0001 || rc_fl_head_o !== 6'd10) begin
      errors++; $display("FAIL b2b_wrong got %b/%b/%b/%0d exp 1/0000/0001/10", rc_vld_o, br_mask_o, sq_mask_o, rc_fl_head_o); end
    checks++; if (rc_mt_o !== make_snap(0)) begin errors++; $display("FAIL b2b_rc_mt got %h exp %h", rc_mt_o, make_snap(0)); end
    tick();
    checks++; if (rc_vld_o !== 1'b0 || sq_mask_o !== 4'b0000) begin errors++; $display("FAIL b2b_drop got %b/%b exp 0/0000", rc_vld_o, sq_mask_o); end
  endtask

  task automatic test_recover_cdb();
    mt_snap_t exp_mt;
    apply_reset();
    for (int k = 0; k < 4; k++) do_alloc(k, 6'(10 + k));
    alloc_i     = 1'b1;
    mt_snap_i   = make_snap(6);
    res_vld_i   = 1'b1;
    res_wrong_i = 1'b1;
    res_bit_i   = 4'b0010;
    cdb_vld_i   = 1'b1;
    cdb_tag_i   = 6'd9;
    #1;
    checks++; if (alloc_rdy_o !== 1'b0) begin errors++; $display("FAIL rcv_rdy got %b exp 0", alloc_rdy_o); end
    tick();
    idle_inputs();
    exp_mt = make_snap(1);
    exp_mt[1].rdy = 1'b1;
    checks++; if (rc_vld_o !== 1'b1 || br_mask_o !== 4'b0001 || sq_mask_o !== 4'b1110) begin
      errors++; $display("FAIL rcv_sq got %b/%b/%b exp 1/0001/1110", rc_vld_o, br_mask_o, sq_mask_o); end
    checks++; if (rc_fl_head_o !== 6'd11) begin errors++; $display("FAIL rcv_fl got %0d exp 11", rc_fl_head_o); end
    checks++; if (rc_mt_o !== exp_mt) begin errors++; $display("FAIL rcv_cdb_mt got %h exp %h", rc_mt_o, exp_mt); end
    tick();
    checks++; if (rc_vld_o !== 1'b0 || free_cnt_o !== 3'd3) begin errors++; $display("FAIL rcv_drop got %b/%0d exp 0/3", rc_vld_o, free_cnt_o); end
  endtask

  task automatic test_cdb_bypass();
    mt_snap_t s;
    mt_snap_t exp_mt;
    s = make_snap(3);
    s[3].tag = 6'd5;
    alloc_i   = 1'b1;
    mt_snap_i = s;
    fl_head_i = 6'd20;
    cdb_vld_i = 1'b1;
    cdb_tag_i = 6'd5;
    res_vld_i = 1'b1;
    res_bit_i = 4'b0001;
    #1;
    checks++; if (alloc_rdy_o !== 1'b1 || alloc_bit_o !== 4'b0010) begin errors++; $display("FAIL byp_alloc got %b/%b exp 1/0010", alloc_rdy_o, alloc_bit_o); end
    tick();
    idle_inputs();
    checks++; if (br_mask_o !== 4'b0010 || free_cnt_o !== 3'd3) begin errors++; $display("FAIL byp_mask got %b/%0d exp 0010/3", br_mask_o, free_cnt_o); end
    res_vld_i = 1'b1; res_wrong_i = 1'b1; res_bit_i = 4'b0010;
    tick();
    idle_inputs();
    exp_mt = s;
    exp_mt[3].rdy = 1'b1;
    checks++; if (br_mask_o !== 4'b0000 || sq_mask_o !== 4'b0010) begin errors++; $display("FAIL byp_dep got %b/%b exp 0000/0010", br_mask_o, sq_mask_o); end
    checks++; if (rc_mt_o !== exp_mt || rc_fl_head_o !== 6'd20) begin errors++; $display("FAIL byp_rc got fl %0d exp 20 mt %h exp %h", rc_fl_head_o, rc_mt_o, exp_mt); end
    tick();
  endtask

  task automatic test_reset_mid_recovery();
    do_alloc(0, 6'd30);
    do_alloc(1, 6'd31);
    res_vld_i = 1'b1; res_wrong_i = 1'b1; res_bit_i = 4'b0010;
    tick();
    idle_inputs();
    checks++; if (rc_vld_o !== 1'b1 || br_mask_o !== 4'b0001 || rc_fl_head_o !== 6'd31) begin
      errors++; $display("FAIL mid_rc got %b/%b/%0d exp 1/0001/31", rc_vld_o, br_mask_o, rc_fl_head_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rc_vld_o !== 1'b0 || br_mask_o !== 4'b0000 || free_cnt_o !== 3'd4) begin
      errors++; $display("FAIL async_rst got %b/%b/%0d exp 0/0000/4", rc_vld_o, br_mask_o, free_cnt_o); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_alloc_fill();
    test_full_correct();
    test_recover_cdb();
    test_cdb_bypass();
    test_reset_mid_recovery();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
